// File: rtl/synth_pkg.sv
// Shared types, widths and the sample saturation helper for the voice sequencer.
package synth_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;
  // Accumulator width: wide enough to sum several full-scale samples without wrap.
  localparam int ACC_W     = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUT
  } seq_state_t;

  // Clamp the wide accumulator into the signed sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    min_v = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
    if (v > max_v) begin
      return max_v[SAMPLE_W-1:0];
    end else if (v < min_v) begin
      return min_v[SAMPLE_W-1:0];
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/shared_mult.sv
// Two-stage signed multiplier shared by all voices: operands registered,
// then the product registered, so results appear two cycles after input.
module shared_mult
  import synth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] i_a,
  input  logic [OPERAND_W-1:0] i_b,
  output logic [PRODUCT_W-1:0] o_p
);

  logic [OPERAND_W-1:0] r_a;
  logic [OPERAND_W-1:0] r_b;
  logic [PRODUCT_W-1:0] r_p;
  logic [PRODUCT_W-1:0] w_prod;

  // Sign-extend both operands to full product width so the low 64 bits are exact.
  assign w_prod = $signed({{(PRODUCT_W-OPERAND_W){r_a[OPERAND_W-1]}}, r_a})
                * $signed({{(PRODUCT_W-OPERAND_W){r_b[OPERAND_W-1]}}, r_b});

  // Pipeline: capture operands, then capture their product; a new pair every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
      r_p <= w_prod;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/voice_sequencer.sv
// Sequences N_VOICES voice clients once per sample tick, in ascending order,
// summing their samples into a saturated mix and sharing one multiplier.
module voice_sequencer
  import synth_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_tick,
  output logic [N_VOICES-1:0]           voice_start,
  input  logic [N_VOICES-1:0]           voice_finish,
  input  logic [N_VOICES*OPERAND_W-1:0] voice_mult_a,
  input  logic [N_VOICES*OPERAND_W-1:0] voice_mult_b,
  output logic [PRODUCT_W-1:0]          mult_p,
  input  logic [N_VOICES*SAMPLE_W-1:0]  voice_wave,
  output logic [SAMPLE_W-1:0]           mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun_err,
  output logic                          timeout_err
);

  localparam int IDX_W   = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_VOICES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  seq_state_t               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [TIMER_W-1:0]       r_timer;
  logic [SAMPLE_W-1:0]      r_mix_out;
  logic                     r_mix_valid;
  logic                     r_overrun_err;
  logic                     r_timeout_err;

  logic [OPERAND_W-1:0]     w_mult_a [N_VOICES];
  logic [OPERAND_W-1:0]     w_mult_b [N_VOICES];
  logic [SAMPLE_W-1:0]      w_wave   [N_VOICES];
  logic [SAMPLE_W-1:0]      w_sel_wave;
  logic signed [ACC_W-1:0]  w_wave_ext;
  logic                     w_finish;
  logic                     w_timeout;
  logic                     w_op_active;
  logic [OPERAND_W-1:0]     w_op_a;
  logic [OPERAND_W-1:0]     w_op_b;

  // Unpack the flat per-voice buses and decode the one-hot start strobe.
  genvar gi;
  generate
    for (gi = 0; gi < N_VOICES; gi++) begin : g_voice
      assign w_mult_a[gi]    = voice_mult_a[gi*OPERAND_W +: OPERAND_W];
      assign w_mult_b[gi]    = voice_mult_b[gi*OPERAND_W +: OPERAND_W];
      assign w_wave[gi]      = voice_wave[gi*SAMPLE_W +: SAMPLE_W];
      assign voice_start[gi] = (r_state == ST_START) && (r_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_sel_wave  = w_wave[r_idx];
  assign w_wave_ext  = {{(ACC_W-SAMPLE_W){w_sel_wave[SAMPLE_W-1]}}, w_sel_wave};
  assign w_finish    = voice_finish[r_idx];
  assign w_timeout   = (r_timer == TIMER_LAST);

  // Only the voice being served drives the multiplier; idle slots feed zeros.
  assign w_op_active = (r_state == ST_START) || (r_state == ST_WAIT);
  assign w_op_a      = w_op_active ? w_mult_a[r_idx] : '0;
  assign w_op_b      = w_op_active ? w_mult_b[r_idx] : '0;

  shared_mult u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .o_p   (mult_p)
  );

  // Sequencer FSM: start each voice, wait for finish or timeout, then emit the mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_acc         <= '0;
      r_timer       <= '0;
      r_mix_out     <= '0;
      r_mix_valid   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      // A tick while a sample is in flight is dropped but remembered.
      if (sample_tick && (r_state != ST_IDLE)) begin
        r_overrun_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (w_finish || w_timeout) begin
            // A finish coinciding with the timeout still counts as a finish.
            if (w_finish) begin
              r_acc <= r_acc + w_wave_ext;
            end else begin
              r_timeout_err <= 1'b1;
            end
            if (r_idx == IDX_LAST) begin
              r_state <= ST_OUT;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_START;
            end
          end
        end
        ST_OUT: begin
          r_mix_out   <= sat_sample(r_acc);
          r_mix_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mix_out     = r_mix_out;
  assign mix_valid   = r_mix_valid;
  assign busy        = (r_state != ST_IDLE);
  assign overrun_err = r_overrun_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_voice_sequencer.sv
// Scoreboard bench for voice_sequencer: stimulus queues the expected mix,
// a monitor pops and compares on every mix_valid pulse.
module tb_voice_sequencer;

  localparam int NV = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic [NV-1:0]     voice_start;
  logic [NV-1:0]     voice_finish = '0;
  logic [NV*32-1:0]  voice_mult_a = '0;
  logic [NV*32-1:0]  voice_mult_b = '0;
  logic [63:0]       mult_p;
  logic [NV*24-1:0]  voice_wave = '0;
  logic [23:0]       mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun_err;
  logic              timeout_err;

  voice_sequencer #(.N_VOICES(NV), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .voice_start  (voice_start),
    .voice_finish (voice_finish),
    .voice_mult_a (voice_mult_a),
    .voice_mult_b (voice_mult_b),
    .mult_p       (mult_p),
    .voice_wave   (voice_wave),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [23:0] mix;
    logic               to;
    logic               ov;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_valid = 0;
  int     cyc = 0;
  int     start_cyc[NV];
  int     lat_cfg[NV];
  int     cnt[NV];
  bit     mul_en = 1'b0;
  longint prod_exp[NV];
  int     mul_v = -1;
  int     mul_age = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Voice model: finish pulses lat_cfg cycles after start; lat 0 means never finish.
  always @(negedge clk) begin
    voice_finish = '0;
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) cnt[v] = 0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (cnt[v] > 0) begin
          cnt[v]--;
          if (cnt[v] == 0) voice_finish[v] = 1'b1;
        end
      end
      for (int v = 0; v < NV; v++) begin
        if (voice_start[v] && lat_cfg[v] > 0) cnt[v] = lat_cfg[v];
      end
    end
  end

  // Monitor: scoreboard pops, one-hot start check, multiplier latency check.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (voice_start != '0) begin
        chk("voice_start one-hot", $countones(voice_start), 1);
      end
      for (int v = 0; v < NV; v++) begin
        if (voice_start[v]) start_cyc[v] = cyc;
      end
      if (mix_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected mix_valid: mix_out=%0d, no sample outstanding", $signed(mix_out));
        end else begin
          e = exp_q.pop_front();
          chk("mix_out", $signed(mix_out), e.mix);
          chk("timeout_err at mix", {63'b0, timeout_err}, {63'b0, e.to});
          chk("overrun_err at mix", {63'b0, overrun_err}, {63'b0, e.ov});
        end
      end
      if (mul_en) begin
        if (mul_v >= 0) begin
          mul_age++;
          if (mul_age == 1) begin
            chk("mult_p start+1", $signed(mult_p), (mul_v == 0) ? 64'sd0 : prod_exp[mul_v-1]);
          end else if (mul_age == 2) begin
            chk("mult_p start+2", $signed(mult_p), prod_exp[mul_v]);
            mul_v = -1;
          end
        end
        for (int v = 0; v < NV; v++) begin
          if (voice_start[v]) begin
            mul_v = v;
            mul_age = 0;
          end
        end
      end
    end
  end

  task automatic cfg(input int w0, input int w1, input int w2, input int w3,
                     input int l0, input int l1, input int l2, input int l3);
    voice_wave = {24'(w3), 24'(w2), 24'(w1), 24'(w0)};
    lat_cfg[0] = l0;
    lat_cfg[1] = l1;
    lat_cfg[2] = l2;
    lat_cfg[3] = l3;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy timeout: busy still 1 after %0d cycles, expected 0", k);
    end
  endtask

  task automatic run_sample(input int exp_mix, input bit eto, input bit eov, input int extra_at);
    exp_t e;
    int v0 = n_valid;
    e.mix = 24'(exp_mix);
    e.to  = eto;
    e.ov  = eov;
    exp_q.push_back(e);
    pulse_tick();
    if (extra_at > 0) begin
      repeat (extra_at) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
    wait_idle();
    repeat (6) @(negedge clk);
    chk("mix_valid pulses per sample", n_valid - v0, 1);
    chk("busy after sample", {63'b0, busy}, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int v0;
    int k;
    // Operand table: A/B per voice with hand-computed products.
    voice_mult_a = {32'd123456, 32'h80000000, 32'd7, 32'hFFFFFFFD};
    voice_mult_b = {32'd1000,   32'h80000000, 32'hFFFFFFF7, 32'h01000000};
    prod_exp[0] = -64'sd50331648;
    prod_exp[1] = -64'sd63;
    prod_exp[2] = 64'sh4000000000000000;
    prod_exp[3] = 64'sd123456000;
    cfg(0, 0, 0, 0, 5, 5, 5, 5);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset mix_out", {40'b0, mix_out}, 0);
    chk("reset mix_valid", {63'b0, mix_valid}, 0);
    chk("reset busy", {63'b0, busy}, 0);
    chk("reset voice_start", {60'b0, voice_start}, 0);
    chk("reset mult_p", $signed(mult_p), 0);
    chk("reset overrun_err", {63'b0, overrun_err}, 0);
    chk("reset timeout_err", {63'b0, timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1 + multiplier latency (scenario 3)
    cfg(1000, -2000, 3000, 4, 5, 5, 5, 5);
    mul_en = 1'b1;
    run_sample(2004, 1'b0, 1'b0, 0);
    mul_en = 1'b0;

    // Scenario 2: saturation and range edges
    cfg(8388607, 8388607, 8388607, 8388607, 3, 3, 3, 3);
    run_sample(8388607, 1'b0, 1'b0, 0);
    cfg(-8388608, -8388608, -8388608, -8388608, 3, 3, 3, 3);
    run_sample(-8388608, 1'b0, 1'b0, 0);
    cfg(8388606, 1, 0, 0, 2, 2, 2, 2);
    run_sample(8388607, 1'b0, 1'b0, 0);
    cfg(8388607, 1, 0, 0, 2, 2, 2, 2);
    run_sample(8388607, 1'b0, 1'b0, 0);
    cfg(-8388608, -1, 0, 0, 2, 2, 2, 2);
    run_sample(-8388608, 1'b0, 1'b0, 0);
    cfg(-8388607, -1, 0, 0, 2, 2, 2, 2);
    run_sample(-8388608, 1'b0, 1'b0, 0);

    // Finish on the very cycle of timeout wins
    cfg(10, 20, 30, 40, 1, 16, 1, 1);
    run_sample(100, 1'b0, 1'b0, 0);

    // Scenario 4: voice 2 never finishes
    cfg(100, 200, 300, 400, 4, 4, 0, 4);
    run_sample(700, 1'b1, 1'b0, 0);
    chk("voice3 start after voice2 WAIT entry", start_cyc[3] - start_cyc[2] - 1, 16);
    // timeout_err stays sticky into the next sample
    cfg(1, 2, 3, 4, 2, 2, 2, 2);
    run_sample(10, 1'b1, 1'b0, 0);

    // One cycle too late: timed out, and the stray finish during START is ignored
    apply_reset();
    cfg(10, 20, 30, 40, 1, 17, 1, 1);
    run_sample(80, 1'b1, 1'b0, 0);

    // Scenario 5: tick during WAIT
    apply_reset();
    cfg(5, 6, 7, 8, 6, 6, 6, 6);
    run_sample(26, 1'b0, 1'b1, 3);

    // Scenario 6: reset during WAIT of voice 1
    cfg(1000, -2000, 3000, 4, 8, 8, 8, 8);
    v0 = n_valid;
    pulse_tick();
    k = 0;
    while (!voice_start[1] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("voice1 started before reset", {63'b0, voice_start[1]}, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {63'b0, busy}, 0);
    chk("async reset voice_start", {60'b0, voice_start}, 0);
    chk("async reset mult_p", $signed(mult_p), 0);
    chk("async reset mix_out", {40'b0, mix_out}, 0);
    chk("async reset mix_valid", {63'b0, mix_valid}, 0);
    chk("async reset overrun_err", {63'b0, overrun_err}, 0);
    chk("async reset timeout_err", {63'b0, timeout_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no mix_valid for abandoned sample", n_valid - v0, 0);
    run_sample(2004, 1'b0, 1'b0, 0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_sequencer.md
VOICE_SEQUENCER -- requirements
Module: voice_sequencer

Interface
REQ-001 Parameter N_VOICES, default 4, SHALL set the number of voice clients sequenced per sample.
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the maximum cycles allowed per voice before it is skipped.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port sample_tick, input, 1 bit, SHALL be a one-cycle pulse requesting one mixed sample.
REQ-006 Port voice_start, output, N_VOICES bits, SHALL be the per-voice start strobe.
REQ-007 Port voice_finish, input, N_VOICES bits, SHALL be the per-voice finish strobe.
REQ-008 Port voice_mult_a, input, N_VOICES x 32 bits, SHALL carry each voice's signed multiplier operand A.
REQ-009 Port voice_mult_b, input, N_VOICES x 32 bits, SHALL carry each voice's signed multiplier operand B.
REQ-010 Port mult_p, output, 64 bits, SHALL be the shared signed product, broadcast to all voices.
REQ-011 Port voice_wave, input, N_VOICES x 24 bits, SHALL carry each voice's signed sample.
REQ-012 Port mix_out, output, 24 bits, SHALL be the saturated signed mix.
REQ-013 Port mix_valid, output, 1 bit, SHALL pulse for one cycle when mix_out updates.
REQ-014 Port busy, output, 1 bit, SHALL be high in any state other than IDLE.
REQ-015 Port overrun_err, output, 1 bit, SHALL be a sticky flag for a sample_tick received while busy.
REQ-016 Port timeout_err, output, 1 bit, SHALL be a sticky flag for a voice skipped on timeout.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT and OUT, with idx (0..N_VOICES-1), a 27-bit signed accumulator acc, and a timer.
REQ-018 In IDLE, a sample_tick SHALL clear idx and acc and move to START; no other input SHALL leave IDLE.
REQ-019 In START, voice_start[idx] SHALL be driven high combinationally for exactly that cycle; the timer SHALL clear; the next state SHALL be WAIT.
REQ-020 In WAIT, voice_finish[idx] high SHALL add sign-extended voice_wave[idx], sampled that cycle, to acc and advance.
REQ-021 In WAIT, timer reaching TIMEOUT-1 without a finish SHALL set timeout_err, add 0 to acc, and advance.
REQ-022 A finish arriving in the same cycle as timeout SHALL win: the sample is added and timeout_err is left unchanged.
REQ-023 Advance SHALL mean idx+1 and a return to START when idx < N_VOICES-1; otherwise the next state SHALL be OUT.
REQ-024 voice_finish bits other than idx, and any voice_finish outside WAIT, SHALL be ignored.
REQ-025 In OUT, mix_out SHALL register acc saturated to the range [-8388608, 8388607], mix_valid SHALL pulse, and the next state SHALL be IDLE.
REQ-026 A sample_tick in START, WAIT or OUT SHALL set overrun_err and otherwise be dropped.
REQ-027 Multiplier operands SHALL be voice_mult_a[idx] and voice_mult_b[idx] in START and WAIT, and 0 in IDLE and OUT.
REQ-028 The multiplier SHALL be a signed 32x32->64 multiplier with two register stages: operands presented in cycle t appear on mult_p in cycle t+2.
REQ-029 The multiplier SHALL be fully pipelined, accepting new operands every cycle.
REQ-030 Voices SHALL be served strictly in ascending index order, one at a time; voice_start SHALL be at most one-hot.

Reset
REQ-031 Asserting rst_n low SHALL asynchronously force: state=IDLE, idx=0, acc=0, timer=0, mix_out=0, mix_valid=0, both error flags=0, both multiplier stages=0 (mult_p=0), voice_start=0.
REQ-032 Reset mid-sample SHALL abandon the sample without producing a mix_valid pulse.
REQ-033 After reset deassertion, the first sample_tick SHALL be accepted normally.

Structure
REQ-034 A shared package synth_pkg SHALL hold the FSM state enum and the constants SAMPLE_W=24, OPERAND_W=32 and PRODUCT_W=64.
REQ-035 synth_pkg SHALL also hold the saturation function used for REQ-025.
REQ-036 The two-stage multiplier SHALL be a sub-module named shared_mult, instantiated once.

Verification
REQ-037 Scenario 1: 4 model voices returning 1000, -2000, 3000, 4 with finish 5 cycles after start -> mix_out=2004, one mix_valid pulse, errors 0.
REQ-038 Scenario 2: four voices each returning 8388607 -> mix_out=8388607; four voices each returning -8388608 -> mix_out=-8388608.
REQ-039 Scenario 3: operands A=-3, B=16777216 presented in START -> mult_p = -50331648 exactly 2 cycles later.
REQ-040 Scenario 4: voice 2 never finishes and TIMEOUT=16 -> voice 3 starts 16 cycles after voice 2's WAIT entry, timeout_err=1, and mix_out excludes voice 2.
REQ-041 Scenario 5: sample_tick during WAIT -> overrun_err=1, exactly one mix_valid for the sample in progress, no extra sample.
REQ-042 Scenario 6: rst_n pulsed low during WAIT of voice 1 -> all outputs 0 immediately, no mix_valid; the next tick completes a full sample.
